// File: rtl/motion_comparator_pkg.sv
// me_pkg: shared defaults, FSM state type and the "no match yet" distortion constant
// used by the motion comparator and its min-tree.
package me_pkg;

   localparam int ME_NUM_PE = 16;
   localparam int ME_DIST_W = 8;
   localparam int ME_VEC_W  = 4;

   localparam logic [ME_DIST_W-1:0] DIST_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      FLUSH,
      DONE
   } meState_t;

endpackage

// File: rtl/motion_comparator_min_tree.sv
// motion_min_tree: combinational reduction over the ready PEs returning the minimum
// distortion with its index and vectors; the lowest index wins on equal distortion.
module motion_min_tree
   import me_pkg::*;
#(
   parameter int NUM_PE = ME_NUM_PE,
   parameter int DIST_W = ME_DIST_W,
   parameter int VEC_W  = ME_VEC_W,
   parameter int IDX_W  = $clog2(ME_NUM_PE)
)(
   input  logic [NUM_PE-1:0]        i_ready,
   input  logic [NUM_PE*DIST_W-1:0] i_dist,
   input  logic [NUM_PE*VEC_W-1:0]  i_vecX,
   input  logic [NUM_PE*VEC_W-1:0]  i_vecY,
   output logic                     o_valid,
   output logic [DIST_W-1:0]        o_dist,
   output logic [IDX_W-1:0]         o_idx,
   output logic [VEC_W-1:0]         o_vecX,
   output logic [VEC_W-1:0]         o_vecY
);

   // Strict less-than while walking upwards keeps the lowest index on ties.
   always_comb begin
      o_valid = 1'b0;
      o_dist  = '1;
      o_idx   = '0;
      o_vecX  = '0;
      o_vecY  = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (i_ready[i] && (!o_valid || (i_dist[i*DIST_W +: DIST_W] < o_dist))) begin
            o_valid = 1'b1;
            o_dist  = i_dist[i*DIST_W +: DIST_W];
            o_idx   = IDX_W'(i);
            o_vecX  = i_vecX[i*VEC_W +: VEC_W];
            o_vecY  = i_vecY[i*VEC_W +: VEC_W];
         end
      end
   end

endmodule

// File: rtl/motion_comparator.sv
// motion_comparator: two-stage best-match reducer with a start/done search handshake.
// Defining MOTION_COMP_EARLY_EXIT_EN adds earlythresh/earlyexit for early termination.
module motion_comparator
   import me_pkg::*;
#(
   parameter int  NUM_PE   = ME_NUM_PE,
   parameter int  DIST_W   = ME_DIST_W,
   parameter int  VEC_W    = ME_VEC_W,
   parameter int  NUM_CAND = 16,
   localparam int IDX_W    = $clog2(NUM_PE),
   localparam int CNT_W    = $clog2(NUM_PE*NUM_CAND) + 1
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     compstart,
   input  logic [NUM_PE-1:0]        peready,
   input  logic [NUM_PE*DIST_W-1:0] peout,
   input  logic [NUM_PE*VEC_W-1:0]  pevecx,
   input  logic [NUM_PE*VEC_W-1:0]  pevecy,
   output logic [IDX_W-1:0]         newpe,
   output logic [VEC_W-1:0]         motionX,
   output logic [VEC_W-1:0]         motionY,
   output logic [DIST_W-1:0]        bestdist,
   output logic                     busy,
   output logic                     compdone,
   output logic [CNT_W-1:0]         candcount
`ifdef MOTION_COMP_EARLY_EXIT_EN
   ,
   input  logic [DIST_W-1:0]        earlythresh,
   output logic                     earlyexit
`endif
);

   localparam logic [CNT_W-1:0] CAND_LIM = CNT_W'(NUM_CAND);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   meState_t r_state, w_nextState;

   logic              r_s1Valid;
   logic [DIST_W-1:0] r_s1Dist;
   logic [IDX_W-1:0]  r_s1Idx;
   logic [VEC_W-1:0]  r_s1VecX, r_s1VecY;

   logic [DIST_W-1:0] r_bestDist;
   logic [IDX_W-1:0]  r_bestIdx;
   logic [VEC_W-1:0]  r_bestVecX, r_bestVecY;
   logic [CNT_W-1:0]  r_candCount;

   logic              w_treeValid;
   logic [DIST_W-1:0] w_treeDist;
   logic [IDX_W-1:0]  w_treeIdx;
   logic [VEC_W-1:0]  w_treeVecX, w_treeVecY;

   logic [CNT_W-1:0]  w_popCount, w_countNext;
   logic [CNT_W:0]    w_countSum;
   logic              w_accept, w_s2Write, w_earlyHit, w_compDone;

   motion_min_tree #(
      .NUM_PE (NUM_PE),
      .DIST_W (DIST_W),
      .VEC_W  (VEC_W),
      .IDX_W  (IDX_W)
   ) u_minTree (
      .i_ready (peready),
      .i_dist  (peout),
      .i_vecX  (pevecx),
      .i_vecY  (pevecy),
      .o_valid (w_treeValid),
      .o_dist  (w_treeDist),
      .o_idx   (w_treeIdx),
      .o_vecX  (w_treeVecX),
      .o_vecY  (w_treeVecY)
   );

   always_comb begin
      w_popCount = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         w_popCount = w_popCount + CNT_W'(peready[i]);
      end
      w_countSum  = {1'b0, r_candCount} + {1'b0, w_popCount};
      w_countNext = w_countSum[CNT_W] ? CNT_MAX : w_countSum[CNT_W-1:0];
   end

   assign w_s2Write = r_s1Valid && (r_s1Dist < r_bestDist);

`ifdef MOTION_COMP_EARLY_EXIT_EN
   assign w_earlyHit = (r_state == SEARCH) && w_s2Write && (r_s1Dist <= earlythresh);
`else
   assign w_earlyHit = 1'b0;
`endif

   // An early hit closes the search in the same cycle, so that cycle's mask is dropped.
   assign w_accept = (r_state == SEARCH) && !compstart && !w_earlyHit && (r_candCount < CAND_LIM);

   always_comb begin
      w_nextState = r_state;
      w_compDone  = 1'b0;
      if (compstart) begin
         w_nextState = SEARCH;
      end else begin
         case (r_state)
            SEARCH: begin
               if (w_earlyHit || (r_candCount >= CAND_LIM) ||
                   (w_accept && (w_countNext >= CAND_LIM))) begin
                  w_nextState = FLUSH;
               end
            end
            FLUSH: begin
               if (!r_s1Valid) begin
                  w_compDone  = 1'b1;
                  w_nextState = DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1Valid   <= 1'b0;
         r_s1Dist    <= '1;
         r_s1Idx     <= '0;
         r_s1VecX    <= '0;
         r_s1VecY    <= '0;
         r_bestDist  <= '1;
         r_bestIdx   <= '0;
         r_bestVecX  <= '0;
         r_bestVecY  <= '0;
         r_candCount <= '0;
      end else begin
         r_s1Valid <= w_accept && w_treeValid;
         r_s1Dist  <= w_treeDist;
         r_s1Idx   <= w_treeIdx;
         r_s1VecX  <= w_treeVecX;
         r_s1VecY  <= w_treeVecY;
         if (compstart) begin
            r_bestDist  <= '1;
            r_bestIdx   <= '0;
            r_bestVecX  <= '0;
            r_bestVecY  <= '0;
            r_candCount <= '0;
         end else begin
            if (w_s2Write) begin
               r_bestDist <= r_s1Dist;
               r_bestIdx  <= r_s1Idx;
               r_bestVecX <= r_s1VecX;
               r_bestVecY <= r_s1VecY;
            end
            if (w_accept) begin
               r_candCount <= w_countNext;
            end
         end
      end
   end

`ifdef MOTION_COMP_EARLY_EXIT_EN
   logic r_earlyFlag;

   always_ff @(posedge clk) begin
      if (reset || compstart) begin
         r_earlyFlag <= 1'b0;
      end else if (w_earlyHit) begin
         r_earlyFlag <= 1'b1;
      end
   end

   assign earlyexit = r_earlyFlag && (w_compDone || (r_state == DONE));
`endif

   assign newpe     = r_bestIdx;
   assign motionX   = r_bestVecX;
   assign motionY   = r_bestVecY;
   assign bestdist  = r_bestDist;
   assign candcount = r_candCount;
   assign busy      = (r_state == SEARCH) || (r_state == FLUSH);
   assign compdone  = w_compDone;

endmodule

// File: tb/tb_motion_comparator.sv
// tb_motion_comparator: directed scenarios plus randomized traffic checked every cycle
// against a search-level reference model of the best-match comparator.
module tb_motion_comparator;
   import me_pkg::*;

   localparam int NPE   = 16;
   localparam int DW    = 8;
   localparam int VW    = 4;
   localparam int NC    = 4;
   localparam int IW    = $clog2(NPE);
   localparam int CW    = $clog2(NPE*NC) + 1;
   localparam int CNTMX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              compstart;
   logic [NPE-1:0]    peready;
   logic [NPE*DW-1:0] peout;
   logic [NPE*VW-1:0] pevecx;
   logic [NPE*VW-1:0] pevecy;
   logic [IW-1:0]     newpe;
   logic [VW-1:0]     motionX;
   logic [VW-1:0]     motionY;
   logic [DW-1:0]     bestdist;
   logic              busy;
   logic              compdone;
   logic [CW-1:0]     candcount;
`ifdef MOTION_COMP_EARLY_EXIT_EN
   logic [DW-1:0]     earlythresh;
   logic              earlyexit;
`endif

   always #5 clk = ~clk;

   motion_comparator #(
      .NUM_PE   (NPE),
      .DIST_W   (DW),
      .VEC_W    (VW),
      .NUM_CAND (NC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .compstart (compstart),
      .peready   (peready),
      .peout     (peout),
      .pevecx    (pevecx),
      .pevecy    (pevecy),
      .newpe     (newpe),
      .motionX   (motionX),
      .motionY   (motionY),
      .bestdist  (bestdist),
      .busy      (busy),
      .compdone  (compdone),
      .candcount (candcount)
`ifdef MOTION_COMP_EARLY_EXIT_EN
      ,
      .earlythresh (earlythresh),
      .earlyexit   (earlyexit)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] best;
      logic [IW-1:0] idx;
      logic [VW-1:0] vx;
      logic [VW-1:0] vy;
   } snap_t;

   localparam snap_t CLEARED = '{best: 8'hFF, idx: '0, vx: '0, vy: '0};

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] distArr [NPE];
   logic [VW-1:0] vxArr   [NPE];
   logic [VW-1:0] vyArr   [NPE];

   // Search-level model: best so far in arrival order, candidates accepted, and
   // the cycle on which the done pulse is due.
   snap_t mCur, snapD1, snapD2;
   int    mCount, cntD1, doneCycle, cyc, doneSeen, thresh;
   bit    mActive, mEarly, earlyVis, busyFlag, prevStart;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic modelReset();
      mCur      = CLEARED;
      snapD1    = CLEARED;
      snapD2    = CLEARED;
      mCount    = 0;
      cntD1     = 0;
      doneCycle = -1;
      mActive   = 0;
      mEarly    = 0;
      earlyVis  = 0;
      busyFlag  = 0;
      prevStart = 0;
   endtask

   task automatic setBase();
      for (int i = 0; i < NPE; i++) begin
         distArr[i] = 8'd0;
         vxArr[i]   = 4'hF;
         vyArr[i]   = 4'hF;
      end
   endtask

   task automatic setPe(input int pe, input int d, input int x, input int y);
      distArr[pe] = d[DW-1:0];
      vxArr[pe]   = x[VW-1:0];
      vyArr[pe]   = y[VW-1:0];
   endtask

   task automatic applyStimulus(input bit start, input logic [NPE-1:0] mask);
      snap_t expSnap;
      bit    expDone, improved;
      int    pop;
      @(posedge clk);
      #1;
      compstart = start;
      peready   = mask;
      for (int i = 0; i < NPE; i++) begin
         peout[i*DW +: DW]  = distArr[i];
         pevecx[i*VW +: VW] = vxArr[i];
         pevecy[i*VW +: VW] = vyArr[i];
      end
`ifdef MOTION_COMP_EARLY_EXIT_EN
      earlythresh = thresh[DW-1:0];
`endif
      @(negedge clk);
      expSnap = prevStart ? snapD1 : snapD2;
      expDone = (doneCycle == cyc) && !start;
      if (expDone && mEarly) earlyVis = 1;
      checkOutput("bestdist", bestdist, expSnap.best);
      if (expSnap.best != 8'hFF) begin
         checkOutput("newpe", newpe, expSnap.idx);
         checkOutput("motionX", motionX, expSnap.vx);
         checkOutput("motionY", motionY, expSnap.vy);
      end
      checkOutput("candcount", candcount, cntD1);
      checkOutput("compdone", compdone, expDone);
      checkOutput("busy", busy, busyFlag);
`ifdef MOTION_COMP_EARLY_EXIT_EN
      checkOutput("earlyexit", earlyexit, earlyVis);
`endif
      if (compdone) doneSeen++;
      if (start) begin
         mCur      = CLEARED;
         mCount    = 0;
         mActive   = 1;
         mEarly    = 0;
         earlyVis  = 0;
         doneCycle = -1;
         busyFlag  = 1;
      end else begin
         if (expDone) busyFlag = 0;
         if (mActive) begin
            improved = 0;
            pop      = 0;
            for (int i = 0; i < NPE; i++) begin
               if (mask[i]) begin
                  pop++;
                  if (distArr[i] < mCur.best) begin
                     mCur     = '{best: distArr[i], idx: IW'(i), vx: vxArr[i], vy: vyArr[i]};
                     improved = 1;
                  end
               end
            end
            mCount = (mCount + pop > CNTMX) ? CNTMX : mCount + pop;
            if (mCount >= NC) begin
               mActive   = 0;
               doneCycle = cyc + 2;
            end
`ifdef MOTION_COMP_EARLY_EXIT_EN
            else if (improved && (int'(mCur.best) <= thresh)) begin
               mActive   = 0;
               mEarly    = 1;
               doneCycle = cyc + 2;
            end
`endif
         end
      end
      snapD2    = snapD1;
      snapD1    = mCur;
      cntD1     = mCount;
      prevStart = start;
      cyc++;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      compstart = 1'b0;
      peready   = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_bestdist", bestdist, DIST_MAX);
      checkOutput("rst_newpe", newpe, 0);
      checkOutput("rst_motionX", motionX, 0);
      checkOutput("rst_motionY", motionY, 0);
      checkOutput("rst_candcount", candcount, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_compdone", compdone, 0);
      modelReset();
   endtask

   initial begin
      int doneBase;
      logic [NPE-1:0] mask;
      reset     = 1'b1;
      compstart = 1'b0;
      peready   = '0;
      peout     = '0;
      pevecx    = '0;
      pevecy    = '0;
      thresh    = 0;
      cyc       = 0;
      doneSeen  = 0;
`ifdef MOTION_COMP_EARLY_EXIT_EN
      earlythresh = '0;
`endif
      setBase();
      modelReset();
      doReset();

      // Ready PE with no search running is ignored.
      setPe(1, 5, 3, 3);
      applyStimulus(0, 16'h0002);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0);
      checkOutput("t1_bestdist", bestdist, 8'hFF);
      checkOutput("t1_busy", busy, 0);
      checkOutput("t1_nodone", doneSeen, 0);

      // Four one-hot candidates on consecutive cycles.
      setBase();
      doneBase = doneSeen;
      applyStimulus(1, '0);
      setPe(2, 8, 5, 6); applyStimulus(0, 16'h0004);
      setPe(3, 3, 7, 5); applyStimulus(0, 16'h0008);
      setPe(6, 7, 8, 6); applyStimulus(0, 16'h0040);
      checkOutput("t2_best_after_pe2", bestdist, 8);
      setPe(4, 1, 1, 2); applyStimulus(0, 16'h0010);
      checkOutput("t2_best_after_pe3", bestdist, 3);
      checkOutput("t2_mx_after_pe3", motionX, 7);
      checkOutput("t2_my_after_pe3", motionY, 5);
      applyStimulus(0, '0);
      checkOutput("t2_best_after_pe6", bestdist, 3);
      applyStimulus(0, '0);
      applyStimulus(0, '0);
      checkOutput("t2_bestdist", bestdist, 1);
      checkOutput("t2_motionX", motionX, 1);
      checkOutput("t2_motionY", motionY, 2);
      checkOutput("t2_newpe", newpe, 4);
      checkOutput("t2_candcount", candcount, 4);
      applyStimulus(0, '0);
      applyStimulus(0, '0);
      checkOutput("t2_one_done", doneSeen - doneBase, 1);

      // Start cycle carries an all-zero-distance mask that must be ignored; then a tie.
      setBase();
      doneBase = doneSeen;
      applyStimulus(1, 16'hFFFF);
      setPe(4, 9, 2, 3); setPe(5, 9, 4, 4);
      applyStimulus(0, 16'h0030);
      applyStimulus(0, '0);
      applyStimulus(0, '0);
      checkOutput("t3_newpe", newpe, 4);
      checkOutput("t3_bestdist", bestdist, 9);
      checkOutput("t3_candcount", candcount, 2);

      // Equal distortion from a later cycle keeps the earlier best.
      setPe(3, 3, 7, 5); applyStimulus(0, 16'h0008);
      applyStimulus(0, '0);
      applyStimulus(0, '0);
      checkOutput("t4_newpe_first", newpe, 3);
      setPe(7, 3, 9, 9); applyStimulus(0, 16'h0080);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0);
      checkOutput("t4_newpe", newpe, 3);
      checkOutput("t4_motionX", motionX, 7);
      checkOutput("t4_motionY", motionY, 5);
      checkOutput("t4_one_done", doneSeen - doneBase, 1);

      // Restart after two of four candidates.
      setBase();
      doneBase = doneSeen;
      applyStimulus(1, '0);
      setPe(0, 10, 1, 1); applyStimulus(0, 16'h0001);
      setPe(1, 11, 2, 2); applyStimulus(0, 16'h0002);
      applyStimulus(1, '0);
      applyStimulus(0, '0);
      checkOutput("t5_bestdist", bestdist, 8'hFF);
      checkOutput("t5_candcount", candcount, 0);
      for (int i = 0; i < 4; i++) begin
         setPe(i, 20 + i, i, i);
         applyStimulus(0, NPE'(1) << i);
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, '0);
      checkOutput("t5_one_done", doneSeen - doneBase, 1);
      checkOutput("t5_bestdist_final", bestdist, 20);

`ifdef MOTION_COMP_EARLY_EXIT_EN
      // Early exit once the best drops to the threshold.
      setBase();
      thresh   = 2;
      doneBase = doneSeen;
      applyStimulus(1, '0);
      setPe(0, 5, 1, 1); applyStimulus(0, 16'h0001);
      setPe(1, 2, 3, 4); applyStimulus(0, 16'h0002);
      setPe(2, 0, 6, 6); applyStimulus(0, 16'h0004);
      applyStimulus(0, '0);
      applyStimulus(0, '0);
      checkOutput("t6_done", doneSeen - doneBase, 1);
      checkOutput("t6_earlyexit", earlyexit, 1);
      checkOutput("t6_bestdist", bestdist, 2);
      checkOutput("t6_candcount", candcount, 2);
`endif

      // Reset in the middle of a search.
      setBase();
      applyStimulus(1, '0);
      setPe(0, 4, 1, 1); applyStimulus(0, 16'h0001);
      applyStimulus(0, 16'h0001);
      doReset();

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         bit start;
         int r;
         for (int i = 0; i < NPE; i++) begin
            distArr[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
            vxArr[i]   = 4'($urandom);
            vyArr[i]   = 4'($urandom);
         end
         r = $urandom_range(0, 9);
         if (r == 0)      mask = '0;
         else if (r < 4)  mask = NPE'(1) << $urandom_range(0, NPE - 1);
         else if (r < 7)  mask = NPE'($urandom & $urandom);
         else             mask = NPE'($urandom & $urandom & $urandom);
         start = (!mActive && !busyFlag) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         if (start) thresh = $urandom_range(0, 12);
         if ($urandom_range(0, 199) == 0) doReset();
         else applyStimulus(start, mask);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
